// File: rtl/key_emu.sv
// -----------------------------------------------------------------------------
// key_emu -- key-press emulator (drive side of the push-button interface)
//
// Accepts press requests over a valid/ready handshake and drives four
// active-low key lines through a press / hold / release sequence. Stands in
// for the physical KEY1..KEY4 inputs ahead of the key-scan/debounce logic.
//
// Optional feature macro: KEY_EMU_BOUNCE_EN
//   defined   : press and release edges are each a burst of BOUNCE_EDGES
//               toggles with pseudo-random gaps (lfsr[7:0]+1 cycles).
//   undefined : clean single press and release edges; LFSR and bounce
//               states are not built, BOUNCE_EDGES and SEED are ignored.
//
// Parameters
//   HOLD_CYC     cycles the settled press is held (1 .. 2^24-1)
//   BOUNCE_EDGES toggles per bounce burst (odd, >= 1)
//   SEED         LFSR reset value (non-zero)
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   press request valid
//   req_mask   in   [3:0] keys to press together (bit0 = KEY1)
//   req_ready  out  high only while idle
//   key_out    out  [3:0] emulated key lines, active-low, idle 4'b1111
//   busy       out  high whenever a sequence is in flight
//   done       out  one-cycle pulse when the sequence completes
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module key_emu #(
  parameter int unsigned HOLD_CYC     = 10_000_000,
  parameter int unsigned BOUNCE_EDGES = 7,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_mask,
  output logic       req_ready,
  output logic [3:0] key_out,
  output logic       busy,
  output logic       done
);

  localparam logic [23:0] HOLD_LOAD = 24'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef KEY_EMU_BOUNCE_EN
    S_PBOUNCE,
    S_RBOUNCE,
`endif
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [3:0]  mask_q;
  logic [3:0]  key_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic [23:0] hold_q;

`ifdef KEY_EMU_BOUNCE_EN
  localparam logic [15:0] TOG_LOAD = 16'(BOUNCE_EDGES - 1);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [7:0]  gap_q;   // cycles still to wait before the next toggle, minus one
  logic [15:0] tog_q;   // toggles still to come in the current burst

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign lfsr_d = lfsr_next(lfsr_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= 4'b0000;
      key_q   <= 4'b1111;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 24'd0;
`ifdef KEY_EMU_BOUNCE_EN
      lfsr_q  <= SEED;
      gap_q   <= 8'd0;
      tog_q   <= 16'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            // First press edge happens on the accept edge itself, so the
            // lines are low in the first cycle after accept.
            mask_q  <= req_mask;
            key_q   <= ~req_mask;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef KEY_EMU_BOUNCE_EN
            // Every toggle loads the gap to the next one and steps the LFSR.
            lfsr_q  <= lfsr_d;
            gap_q   <= lfsr_q[7:0];
            if (BOUNCE_EDGES <= 1) begin
              hold_q  <= HOLD_LOAD;
              state_q <= S_HOLD;
            end else begin
              tog_q   <= TOG_LOAD;
              state_q <= S_PBOUNCE;
            end
`else
            hold_q  <= HOLD_LOAD;
            state_q <= S_HOLD;
`endif
          end
        end

`ifdef KEY_EMU_BOUNCE_EN
        S_PBOUNCE: begin
          if (gap_q == 8'd0) begin
            key_q  <= key_q ^ mask_q;
            lfsr_q <= lfsr_d;
            gap_q  <= lfsr_q[7:0];
            tog_q  <= tog_q - 16'd1;
            // Odd toggle count: the last toggle leaves the lines low and
            // starts the settled hold.
            if (tog_q == 16'd1) begin
              hold_q  <= HOLD_LOAD;
              state_q <= S_HOLD;
            end
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end

        S_RBOUNCE: begin
          if (gap_q == 8'd0) begin
            key_q  <= key_q ^ mask_q;
            lfsr_q <= lfsr_d;
            gap_q  <= lfsr_q[7:0];
            tog_q  <= tog_q - 16'd1;
            // Last release toggle leaves the lines high; done coincides.
            if (tog_q == 16'd1) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
`endif

        S_HOLD: begin
          if (hold_q == 24'd0) begin
            // First release edge follows the last held cycle directly.
            key_q <= key_q ^ mask_q;
`ifdef KEY_EMU_BOUNCE_EN
            lfsr_q <= lfsr_d;
            gap_q  <= lfsr_q[7:0];
            if (BOUNCE_EDGES <= 1) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              tog_q   <= TOG_LOAD;
              state_q <= S_RBOUNCE;
            end
`else
            done_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end else begin
            hold_q <= hold_q - 24'd1;
          end
        end

        S_DONE: begin
          key_q   <= 4'b1111;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          key_q   <= 4'b1111;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign key_out   = key_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_emu.sv
`timescale 1ns/1ps
module tb_key_emu;

  localparam int          HOLD = 10;
  localparam int          BE   = 5;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef KEY_EMU_BOUNCE_EN
  localparam int NE = BE;
`else
  localparam int NE = 1;
`endif

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_mask;
  logic       req_ready;
  logic [3:0] key_out;
  logic       busy;
  logic       done;

  key_emu #(
    .HOLD_CYC    (HOLD),
    .BOUNCE_EDGES(BE),
    .SEED        (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_mask (req_mask),
    .req_ready(req_ready),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference LFSR state, stepped once per expected toggle.
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int next_gap();
    int g;
`ifdef KEY_EMU_BOUNCE_EN
    g = int'(m_lfsr[7:0]) + 1;
    m_lfsr = lfsr_step(m_lfsr);
`else
    g = 1;
`endif
    return g;
  endfunction

  // Issue one request and check every cycle until the first idle cycle.
  // Cycle k is sampled on the falling edge after the k-th rising edge
  // counted from the accept edge (k=1 is the first cycle after accept).
  // noise: keep req_valid high with noise_mask while busy.
  // abort: return mid-hold without finishing the sequence.
  task automatic run_seq(input string name, input logic [3:0] mask,
                         input bit noise, input logic [3:0] noise_mask,
                         input bit abort);
    int t[$];
    int cur, tp, tr, g, ntog, abort_k;
    logic [3:0] ek;
    cur = 1;
    for (int i = 0; i < NE; i++) begin
      t.push_back(cur);
      g = next_gap();
      if (i < NE - 1) cur += g;
    end
    tp = cur;
    cur = tp + HOLD;
    for (int i = 0; i < NE; i++) begin
      t.push_back(cur);
      g = next_gap();
      if (i < NE - 1) cur += g;
    end
    tr = cur;
    abort_k = tp + HOLD / 2;

    chk({name, " ready_at_req"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_mask  = mask;
    @(posedge clk);
    #1;
    if (noise) req_mask = noise_mask;
    else       req_valid = 1'b0;
    for (int k = 1; k <= tr + 1; k++) begin
      @(negedge clk);
      ntog = 0;
      foreach (t[j]) if (t[j] <= k) ntog++;
      ek = ntog[0] ? ~mask : 4'b1111;
      chk($sformatf("%s key k=%0d", name, k), 32'(key_out), 32'(ek));
      chk($sformatf("%s done k=%0d", name, k), 32'(done), 32'(k == tr));
      chk($sformatf("%s busy k=%0d", name, k), 32'(busy), 32'(k <= tr));
      chk($sformatf("%s ready k=%0d", name, k), 32'(req_ready), 32'(k > tr));
      if (abort && k == abort_k) return;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mask  = 4'b0000;
    m_lfsr    = SEED;

    // Reset state
    @(negedge clk);
    chk("rst key_out", 32'(key_out), 32'hF);
    chk("rst ready",   32'(req_ready), 32'd1);
    chk("rst busy",    32'(busy), 32'd0);
    chk("rst done",    32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle key_out", 32'(key_out), 32'hF);

    // Single key, then two keys together
    run_seq("m0001", 4'b0001, 1'b0, 4'b0000, 1'b0);
    run_seq("m1010", 4'b1010, 1'b0, 4'b0000, 1'b0);

    // req_valid held high; masks offered while busy must never be used
    run_seq("b2b_a", 4'b0110, 1'b1, 4'b1001, 1'b0);
    run_seq("b2b_b", 4'b0101, 1'b1, 4'b1111, 1'b0);

    // Empty mask: fully timed, lines never move
    run_seq("m0000", 4'b0000, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("idle after m0000 busy", 32'(busy), 32'd0);

    // Reset in the middle of the hold
    run_seq("abort", 4'b1100, 1'b0, 4'b0000, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async rst key_out", 32'(key_out), 32'hF);
    chk("async rst busy",    32'(busy), 32'd0);
    chk("async rst ready",   32'(req_ready), 32'd1);
    chk("async rst done",    32'(done), 32'd0);
    @(negedge clk);
    chk("rst hold done", 32'(done), 32'd0);
    rst = 1'b0;
    m_lfsr = SEED;
    @(negedge clk);
    chk("post rst done", 32'(done), 32'd0);

    // First request after reset repeats the first-after-reset sequence
    run_seq("after_rst", 4'b1010, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("final idle key_out", 32'(key_out), 32'hF);
    chk("final idle ready",   32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/key_emu.md
# key_emu

Key-press emulator: the drive side of the push-button interface. It takes press requests over a valid/ready handshake and drives four active-low key lines with a press, hold and release sequence. Optionally it adds pseudo-random contact bounce. It sits ahead of the board key-scan/debounce logic for loopback self-test and bench stimulus, replacing the physical KEY1–KEY4 inputs.

## Interface
Parameters:
- HOLD_CYC, 10_000_000: cycles the settled press is held (200 ms at 50 MHz). Minimum 1.
- BOUNCE_EDGES, 7: toggles per bounce burst. Must be odd and ≥1.
- SEED, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  press request valid
- req_mask  in  4  keys to press together (bit0 = KEY1)
- req_ready  out  1  high only in IDLE
- key_out  out  4  emulated key lines, active-low, idle 4'b1111
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence completes

## Operation
- Accept: a request is accepted on a clk edge where req_valid & req_ready. req_mask is captured in mask_r. req_valid while busy is ignored; no queueing.
- FSM states: IDLE → P_BOUNCE → HOLD → R_BOUNCE → DONE → IDLE.
- P_BOUNCE:
  - The first toggle drives the masked lines low in the cycle after accept.
  - BOUNCE_EDGES toggles total.
  - The gap before each subsequent toggle is lfsr[7:0]+1 cycles (1..256). The gap is loaded when the previous toggle occurs.
  - Because the toggle count is odd, the lines end low.
- HOLD: masked lines held low for exactly HOLD_CYC cycles.
- R_BOUNCE: same as P_BOUNCE but starting from low. The first toggle drives the lines high in the cycle after HOLD ends, and the lines end high.
- DONE: one cycle. done=1, key_out=1111. The next state is IDLE.
- Unmasked lines stay 1 throughout.
- LFSR:
  - 16-bit Fibonacci: next = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
  - Advances once per toggle.
  - Not reseeded between requests.
- req_mask = 0: accepted and fully timed (bounce gaps and hold consumed), key_out stays 1111, done pulses normally.
- Hold counter is 24 bits; HOLD_CYC must be < 2^24.

## Timing
- Reset values: key_out=4'b1111, req_ready=1, busy=0, done=0, state=IDLE, lfsr=SEED, counters=0.
- Reset mid-sequence: all outputs return to reset values asynchronously. The in-flight request is discarded with no done pulse.
- All outputs are registered.
- Accept at edge T: busy=1 and req_ready=0 from T+1.
- Sequence length: first press toggle at T+1, then a settled low of exactly HOLD_CYC cycles, then the release burst, then done for one cycle, then req_ready=1 in the following cycle.
- Clean case (BOUNCE_EDGES=1 or bounce compiled out):
  - key_out low from T+1 through T+HOLD_CYC.
  - High again at T+HOLD_CYC+1, with done=1 in that same cycle.
  - req_ready=1 at T+HOLD_CYC+2.
- A new request can be accepted in the first IDLE cycle, giving back-to-back sequences with one idle cycle between them.

## Configuration
- KEY_EMU_BOUNCE_EN defined: P_BOUNCE and R_BOUNCE are compiled in as described.
- KEY_EMU_BOUNCE_EN undefined: bounce states and LFSR are removed. Transitions are IDLE → HOLD → DONE → IDLE. The press edge comes the cycle after accept, the release edge the cycle after HOLD, and BOUNCE_EDGES is ignored. Timing is identical to the clean case above.

## Test plan
- Reset, then mask 4'b0001 with HOLD_CYC=10 and bounce off → key_out[0] low for exactly 10 cycles starting T+1; done at T+11; req_ready at T+12; other bits stay 1.
- Bounce on, BOUNCE_EDGES=5, SEED=16'hACE1, mask 4'b1010 →
  - Exactly 5 toggles on bits 1 and 3 before HOLD, each gap matching the reference LFSR model.
  - 10-cycle settled low.
  - 5 toggles ending high.
  - One done pulse.
- req_valid held high with alternating masks across two sequences → the second mask is accepted only in the IDLE cycle after done; the mask presented while busy is never used.
- mask 4'b0000 → key_out stays 1111 throughout; done pulses after the same cycle count as a non-zero-mask sequence with the same LFSR state.
- rst asserted mid-HOLD → key_out=1111, busy=0, req_ready=1 immediately with no done pulse; lfsr=SEED; the next request behaves as the first after reset.
- Loopback into the key-scan block with HOLD_CYC=2_000_000 → exactly one LED toggle per emulated press with bounce enabled.
